dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port 4K x 32 data memory between the pipeline memory stage (primary port P) and a secondary requester (port S: program/data loader or debug bridge).
- Sits between stage_memory's dmem signals and the dmem macro. Issues exactly one access per cycle.
- Gives P priority, guarded by a starvation counter that forces an S grant and stalls the pipeline for one cycle.

Parameters:
ADDR_W, 12, dmem word-address width
DATA_W, 32, dmem data width
STARVE_LIMIT, 4, consecutive denied S cycles before S is forced through (range 1..15)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
p_req  in  1  pipeline memory stage needs dmem this cycle (lw or sw)
p_we  in  1  pipeline access is a store
p_addr  in  ADDR_W  pipeline address (ALU result [11:0])
p_wdata  in  DATA_W  pipeline store data
p_rdata  out  DATA_W  load data to pipeline
p_stall  out  1  pipeline must hold F/D/X/M and retry
s_req  in  1  secondary request; held, with fields stable, until s_gnt
s_we  in  1  secondary access is a write
s_addr  in  ADDR_W  secondary address
s_wdata  in  DATA_W  secondary write data
s_gnt  out  1  secondary access issued this cycle
s_rvalid  out  1  secondary read data valid
s_rdata  out  DATA_W  secondary read data
address_dmem  out  ADDR_W  to dmem
d_dmem  out  DATA_W  to dmem
wren  out  1  to dmem
q_dmem  in  DATA_W  from dmem, valid one cycle after address
stall_count  out  32  stall-cycle counter (optional feature)

Behaviour:
- Registered state: starve_cnt (4 bits), starve flag (starve_cnt == STARVE_LIMIT), owner_q in {NONE, P, S}, s_rd_q.
- Grant logic (combinational, depends only on inputs and registers; no loop through p_stall):
  - s_win = s_req & (~p_req | starve)
  - s_gnt = s_win
  - p_stall = p_req & s_win
- Mux: s_win selects the S fields onto address_dmem/d_dmem. Otherwise the P fields are selected.
- wren = s_win ? s_we : (p_req & p_we). wren is never 1 unless a request was selected.
- Idle (no request): address_dmem = p_addr, d_dmem = p_wdata, wren = 0.
- starve_cnt:
  - Cleared when s_req = 0 or s_gnt = 1.
  - Incremented when s_req & ~s_gnt.
  - Saturates at STARVE_LIMIT.
- owner_q next state: S if s_win, else P if p_req, else NONE.
- s_rd_q next = s_win & ~s_we.
- Read latency: one cycle.
  - s_rvalid = s_rd_q; s_rdata = q_dmem in that cycle.
  - p_rdata = q_dmem unconditionally; the pipeline latches it at M/W only for non-stalled loads.
- Stalled P access: does not touch memory. The pipeline re-presents the same request next cycle, and P wins then because starve_cnt was cleared.
- Simultaneous P store and S write to the same address: the winner writes; the stalled P store lands the next cycle. Final value = P data.
- Reset: starve_cnt = 0, owner_q = NONE, s_rd_q = 0, stall_count = 0. Hence s_rvalid = 0 the cycle after reset asserts.
  - An S read granted in the cycle reset is sampled is dropped (no s_rvalid).
  - Outputs that are combinational from inputs follow inputs during reset. p_stall = 0 while starve = 0.

Optional Feature:
- DMEM_ARB_STALL_CNT_EN defined: stall_count increments by 1 on every clock with p_stall = 1, saturates at 32'hFFFFFFFF, and clears on reset.
- Undefined: stall_count is tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package (dmem_arb_pkg):
  - Owner encoding: OWN_NONE = 2'd0, OWN_P = 2'd1, OWN_S = 2'd2.
  - ADDR_W/DATA_W defaults.
  - Opcode constant for sw (5'b00111) and lw (5'b01000), used by the stage that derives p_req/p_we.
- One natural sub-module: dmem_starve_counter. It holds the saturating counter and the starve flag, and takes s_req, s_gnt, and STARVE_LIMIT.

Test Plan:
- P-only lw at 0x010 holding 0xDEADBEEF: s_req = 0 → address_dmem = 0x010, wren = 0, p_stall = 0, p_rdata = 0xDEADBEEF the next cycle.
- S-only write 0x0000_1234 to 0x020, then S read of 0x020: s_gnt = 1 in both issue cycles; s_rvalid = 1 the cycle after the read with s_rdata = 0x0000_1234; p_stall stays 0.
- p_req and s_req held continuously with STARVE_LIMIT = 4: S is denied for 4 cycles, then the 5th cycle has s_gnt = 1 and p_stall = 1. The pattern repeats every 5 cycles.
- Same cycle, P sw 0xAAAA_AAAA and S write 0x5555_5555 to 0x100 while starve = 1: the S write issues first and the P store lands the next cycle. Reading 0x100 returns 0xAAAA_AAAA.
- S read granted, reset asserted on the following edge: s_rvalid = 0, starve_cnt = 0, and stall_count = 0 after reset.
- With DMEM_ARB_STALL_CNT_EN, the 3-starvation-event sequence gives stall_count = 3. Without the macro, stall_count = 0 throughout.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P    = 2'd1,
    OWN_S    = 2'd2
  } owner_e;

  // Opcodes the memory stage decodes into p_req/p_we.
  localparam logic [4:0] OPC_SW = 5'b00111;
  localparam logic [4:0] OPC_LW = 5'b01000;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle of the arbiter: pipeline port P and secondary port S.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              p_req;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] p_rdata;
  logic              p_stall;

  logic              s_req;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_gnt;
  logic              s_rvalid;
  logic [DATA_W-1:0] s_rdata;

  modport master (
    output p_req, p_we, p_addr, p_wdata, s_req, s_we, s_addr, s_wdata,
    input  p_rdata, p_stall, s_gnt, s_rvalid, s_rdata
  );

  modport slave (
    input  p_req, p_we, p_addr, p_wdata, s_req, s_we, s_addr, s_wdata,
    output p_rdata, p_stall, s_gnt, s_rvalid, s_rdata
  );

endinterface

// File: rtl/dmem_starve_counter.sv
// Saturating count of consecutive denied S cycles; starve_o forces the next S grant.
module dmem_starve_counter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic s_req_i,
  input  logic s_gnt_i,
  output logic starve_o
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!s_req_i || s_gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != Limit) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_o = (cnt_q == Limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: pipeline P has priority, S is forced through after starvation.
// Optional stall-cycle counter enabled by DMEM_ARB_STALL_CNT_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  dmem_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] d_dmem,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem,
  output logic [31:0]       stall_count
);

  logic   starve;
  logic   s_win;
  logic   p_stall;
  owner_e owner_q, owner_d;
  logic   s_rd_q, s_rd_d;

  dmem_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock    (clock),
    .reset    (reset),
    .s_req_i  (bus.s_req),
    .s_gnt_i  (s_win),
    .starve_o (starve)
  );

  // Grant depends only on inputs and registered starve, never on p_stall.
  assign s_win   = bus.s_req & (~bus.p_req | starve);
  assign p_stall = bus.p_req & s_win;

  assign bus.s_gnt   = s_win;
  assign bus.p_stall = p_stall;

  always_comb begin
    address_dmem = bus.p_addr;
    d_dmem       = bus.p_wdata;
    wren         = bus.p_req & bus.p_we;
    if (s_win) begin
      address_dmem = bus.s_addr;
      d_dmem       = bus.s_wdata;
      wren         = bus.s_we;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (s_win) begin
      owner_d = OWN_S;
    end else if (bus.p_req) begin
      owner_d = OWN_P;
    end
    s_rd_d = s_win & ~bus.s_we;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      s_rd_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      s_rd_q  <= s_rd_d;
    end
  end

  assign bus.s_rvalid = s_rd_q & (owner_q == OWN_S);
  assign bus.s_rdata  = q_dmem;
  assign bus.p_rdata  = q_dmem;

`ifdef DMEM_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (p_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule
